// File: rtl/boot_seq_pkg.sv
// Shared definitions for the boot sequencer.
//   boot_state_e          : top-level sequencer states
//   bus_state_e           : bus master states
//   DEFAULT_BOOT_REG_ADDR : SoC boot-address register location
//   cycles_to_load        : turns a cycle count into a down-counter load value
package boot_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RST_HOLD,
        RST_WAIT,
        WR_REQ,
        WR_RSP,
        RD_REQ,
        RD_RSP,
        FETCH_DLY,
        RUN,
        DONE,
        ERROR
    } boot_state_e;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_REQ,
        BUS_RSP
    } bus_state_e;

    localparam logic [31:0] DEFAULT_BOOT_REG_ADDR = 32'h1A10_7008;

    // A phase of N cycles loads N-1 and leaves when the counter reads 0.
    // N=0 is treated as N=1, so the counter never wraps.
    function automatic logic [31:0] cycles_to_load(input logic [31:0] cycles);
        return (cycles == 32'd0) ? 32'd0 : cycles - 32'd1;
    endfunction

endpackage

// File: rtl/boot_seq_if.sv
// PULP-style data bus between the boot sequencer (master) and the SoC (slave).
//   data_req_o/addr/we/be/wdata : request from master
//   data_gnt_i                  : slave accepts the request
//   data_rvalid_i/data_rdata_i  : response from slave
//
// Handshake: the master raises data_req_o with addr/we/be/wdata and holds
// all of them stable until it samples data_gnt_i=1 at a clock edge; that edge
// completes the address phase. The response phase completes at the first
// later edge with data_rvalid_i=1 (rdata is valid only in that cycle). A
// raised request is never withdrawn and there is no bound on either wait.
interface boot_seq_if;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i
    );
endinterface

// File: rtl/boot_seq_bus_master.sv
// Single-command bus master for the boot sequencer.
//   clk, rst           : clock, synchronous active-high reset
//   cmd_valid/cmd_we   : issue one read or write (taken when idle, or in the
//   cmd_addr/cmd_wdata   same cycle the previous response completes)
//   granted            : address phase completes this cycle
//   rsp_valid/rsp_rdata: response phase completes this cycle
//   state_o            : debug view of the bus state
//   bus                : master side of the data bus
module boot_seq_bus_master
    import boot_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        granted,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output bus_state_e  state_o,
    boot_seq_if.master  bus
);

    bus_state_e state_q;
    bus_state_e state_d;
    logic       accept;

    assign granted   = (state_q == BUS_REQ) && bus.data_gnt_i;
    assign rsp_valid = (state_q == BUS_RSP) && bus.data_rvalid_i;
    assign rsp_rdata = bus.data_rdata_i;
    assign state_o   = state_q;

    // Back-to-back commands: a new request may start on the edge that
    // completes the previous response.
    assign accept = cmd_valid && ((state_q == BUS_IDLE) || rsp_valid);

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (accept) state_d = BUS_REQ;
            BUS_REQ:  if (bus.data_gnt_i) state_d = BUS_RSP;
            BUS_RSP:  if (rsp_valid) state_d = accept ? BUS_REQ : BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= BUS_IDLE;
            bus.data_req_o   <= 1'b0;
            bus.data_we_o    <= 1'b0;
            bus.data_be_o    <= 4'h0;
            bus.data_addr_o  <= 32'h0;
            bus.data_wdata_o <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                bus.data_req_o   <= 1'b1;
                bus.data_we_o    <= cmd_we;
                bus.data_be_o    <= 4'hF;
                bus.data_addr_o  <= cmd_addr;
                bus.data_wdata_o <= cmd_wdata;
            end else if (granted) begin
                // Address/data keep their last values; only req drops.
                bus.data_req_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: holds the core in reset, programs and verifies the SoC
// boot-address register over the data bus, enables instruction fetch and
// then watches a GPIO bit for end-of-computation (with optional timeout).
//   clk, rst          : clock, synchronous active-high reset
//   start_i           : one-cycle start request (honoured in IDLE/DONE/ERROR)
//   core_rst_n_o      : active-low core reset
//   fetch_enable_o    : core fetch enable
//   bus               : master side of the data bus
//   gpio_out_i        : SoC GPIO; bit DONE_BIT signals completion
//   busy_o/done_o/error_o/timeout_o : status flags
//   state_o, bus_state_o : debug views of the FSMs
// All outputs are registered and reflect the state being entered.
module boot_sequencer
    import boot_seq_pkg::*;
#(
    parameter logic [31:0] RST_HOLD_CYCLES  = 32'd50,
    parameter logic [31:0] RST_WAIT_CYCLES  = 32'd50,
    parameter logic [31:0] FETCH_DLY_CYCLES = 32'd20,
    parameter logic [31:0] BOOT_REG_ADDR    = DEFAULT_BOOT_REG_ADDR,
    parameter logic [31:0] BOOT_ADDR        = 32'h0000_0000,
    parameter int unsigned DONE_BIT         = 8,
    parameter logic [31:0] TIMEOUT_CYCLES   = 32'd100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic        core_rst_n_o,
    output logic        fetch_enable_o,
    boot_seq_if.master  bus,
    input  logic [31:0] gpio_out_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        timeout_o,
    output boot_state_e state_o,
    output bus_state_e  bus_state_o
);

    localparam logic [31:0] HOLD_LOAD  = cycles_to_load(RST_HOLD_CYCLES);
    localparam logic [31:0] WAIT_LOAD  = cycles_to_load(RST_WAIT_CYCLES);
    localparam logic [31:0] FETCH_LOAD = cycles_to_load(FETCH_DLY_CYCLES);
    localparam logic [31:0] RUN_LOAD   = cycles_to_load(TIMEOUT_CYCLES);
    localparam logic [4:0]  DONE_IDX   = 5'(DONE_BIT);

    boot_state_e state_q;
    boot_state_e state_d;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        cmd_valid;
    logic        cmd_we;
    logic        timeout_set;
    logic        granted;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    // Only the done bit of the GPIO word is meaningful here.
    logic gpio_unused;
    assign gpio_unused = ^gpio_out_i;

    assign state_o = state_q;

    boot_seq_bus_master u_bus_master (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_we    (cmd_we),
        .cmd_addr  (BOOT_REG_ADDR),
        .cmd_wdata (BOOT_ADDR),
        .granted   (granted),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .state_o   (bus_state_o),
        .bus       (bus)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_valid   = 1'b0;
        cmd_we      = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    state_d = RST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            RST_HOLD: begin
                if (cnt_q == 32'd0) begin
                    state_d = RST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            RST_WAIT: begin
                // The write is issued on the edge that enters WR_REQ so that
                // data_req_o is already high in the first WR_REQ cycle.
                if (cnt_q == 32'd0) begin
                    state_d   = WR_REQ;
                    cmd_valid = 1'b1;
                    cmd_we    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            WR_REQ: if (granted) state_d = WR_RSP;
            WR_RSP: begin
                if (rsp_valid) begin
                    state_d   = RD_REQ;
                    cmd_valid = 1'b1;
                end
            end
            RD_REQ: if (granted) state_d = RD_RSP;
            RD_RSP: begin
                if (rsp_valid) begin
                    if (rsp_rdata == BOOT_ADDR) begin
                        state_d = FETCH_DLY;
                        cnt_d   = FETCH_LOAD;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            FETCH_DLY: begin
                if (cnt_q == 32'd0) begin
                    state_d = RUN;
                    cnt_d   = RUN_LOAD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            RUN: begin
                // Done bit has priority over an expiring timeout.
                if (gpio_out_i[DONE_IDX]) begin
                    state_d = DONE;
                end else if (TIMEOUT_CYCLES != 32'd0) begin
                    if (cnt_q == 32'd0) begin
                        state_d     = ERROR;
                        timeout_set = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 32'd0;
            core_rst_n_o   <= 1'b0;
            fetch_enable_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
            timeout_o      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            core_rst_n_o   <= !((state_d == IDLE) || (state_d == RST_HOLD) ||
                                (state_d == ERROR));
            fetch_enable_o <= (state_d == RUN) || (state_d == DONE);
            busy_o         <= !((state_d == IDLE) || (state_d == DONE) ||
                                (state_d == ERROR));
            done_o         <= (state_d == DONE);
            error_o        <= (state_d == ERROR);
            // ERROR is only left through a start, which clears the flag.
            timeout_o      <= timeout_set || (timeout_o && (state_d == ERROR));
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
module tb_boot_sequencer;
    import boot_seq_pkg::*;

    localparam logic [31:0] HOLD      = 32'd50;
    localparam logic [31:0] WAIT      = 32'd50;
    localparam logic [31:0] FDLY      = 32'd20;
    localparam logic [31:0] TMO       = 32'd1000;
    localparam logic [31:0] REG_ADDR  = 32'h1A10_7008;
    localparam logic [31:0] BOOT_VAL  = 32'h0000_0000;
    localparam logic [31:0] DONE_MASK = 32'h0000_0100;
    localparam int          LIMIT     = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] gpio_out_i;
    logic        core_rst_n_o;
    logic        fetch_enable_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic        timeout_o;
    boot_state_e state_o;
    bus_state_e  bus_state_o;

    int total = 0;
    int bad   = 0;

    boot_seq_if bus ();

    boot_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .core_rst_n_o   (core_rst_n_o),
        .fetch_enable_o (fetch_enable_o),
        .bus            (bus),
        .gpio_out_i     (gpio_out_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .timeout_o      (timeout_o),
        .state_o        (state_o),
        .bus_state_o    (bus_state_o)
    );

    // clock
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk1({tag, ".core_rst_n"}, core_rst_n_o, 1'b0);
        chk1({tag, ".fetch"}, fetch_enable_o, 1'b0);
        chk1({tag, ".req"}, bus.data_req_o, 1'b0);
        chk1({tag, ".we"}, bus.data_we_o, 1'b0);
        chk({tag, ".be"}, {28'h0, bus.data_be_o}, 32'h0);
        chk({tag, ".addr"}, bus.data_addr_o, 32'h0);
        chk({tag, ".wdata"}, bus.data_wdata_o, 32'h0);
        chk1({tag, ".busy"}, busy_o, 1'b0);
        chk1({tag, ".done"}, done_o, 1'b0);
        chk1({tag, ".error"}, error_o, 1'b0);
        chk1({tag, ".timeout"}, timeout_o, 1'b0);
        chk({tag, ".state"}, {28'h0, state_o}, {28'h0, IDLE});
    endtask

    // Start pulse, then measure reset-hold and settle lengths; ends in the
    // first cycle of the write request.
    task automatic start_seq(input string tag);
        int n;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk1({tag, ".start_core_rst_n"}, core_rst_n_o, 1'b0);
        chk1({tag, ".start_busy"}, busy_o, 1'b1);
        chk1({tag, ".start_done"}, done_o, 1'b0);
        chk1({tag, ".start_error"}, error_o, 1'b0);
        chk1({tag, ".start_timeout"}, timeout_o, 1'b0);
        chk1({tag, ".start_fetch"}, fetch_enable_o, 1'b0);
        n = 0;
        while (core_rst_n_o !== 1'b1 && n < LIMIT) begin
            n++;
            tick();
        end
        chk({tag, ".hold_len"}, n, HOLD);
        n = 0;
        while (bus.data_req_o !== 1'b1 && n < LIMIT) begin
            n++;
            tick();
        end
        chk({tag, ".wait_len"}, n, WAIT);
        chk1({tag, ".wait_core_rst_n"}, core_rst_n_o, 1'b1);
        chk1({tag, ".wait_busy"}, busy_o, 1'b1);
    endtask

    // Slave withholds grant for gdly cycles; request must stay put.
    task automatic hold_no_grant(input string tag, input logic we, input int gdly);
        int unstable;
        chk1({tag, ".req"}, bus.data_req_o, 1'b1);
        chk1({tag, ".we"}, bus.data_we_o, we);
        chk({tag, ".addr"}, bus.data_addr_o, REG_ADDR);
        chk({tag, ".be"}, {28'h0, bus.data_be_o}, 32'hF);
        if (we) chk({tag, ".wdata"}, bus.data_wdata_o, BOOT_VAL);
        unstable = 0;
        bus.data_gnt_i = 1'b0;
        for (int k = 0; k < gdly; k++) begin
            tick();
            if (bus.data_req_o !== 1'b1 || bus.data_we_o !== we ||
                bus.data_addr_o !== REG_ADDR || bus.data_be_o !== 4'hF ||
                (we && bus.data_wdata_o !== BOOT_VAL))
                unstable++;
        end
        chk({tag, ".unstable_cycles"}, unstable, 32'd0);
    endtask

    task automatic bus_xfer(input string tag, input logic we, input int gdly,
                            input int rdly, input logic [31:0] rdata);
        int stray;
        hold_no_grant(tag, we, gdly);
        bus.data_gnt_i = 1'b1;
        tick();
        bus.data_gnt_i = 1'b0;
        chk1({tag, ".req_after_gnt"}, bus.data_req_o, 1'b0);
        stray = 0;
        for (int k = 1; k < rdly; k++) begin
            tick();
            if (bus.data_req_o !== 1'b0) stray++;
        end
        chk({tag, ".req_in_rsp_wait"}, stray, 32'd0);
        bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i  = rdata;
        tick();
        bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i  = $urandom;
    endtask

    task automatic fetch_phase(input string tag);
        int n;
        chk1({tag, ".fd_error"}, error_o, 1'b0);
        chk1({tag, ".fd_req"}, bus.data_req_o, 1'b0);
        n = 0;
        while (fetch_enable_o !== 1'b1 && n < LIMIT) begin
            n++;
            tick();
        end
        chk({tag, ".fetch_dly_len"}, n, FDLY);
        chk1({tag, ".run_busy"}, busy_o, 1'b1);
        chk1({tag, ".run_core_rst_n"}, core_rst_n_o, 1'b1);
        chk1({tag, ".run_done"}, done_o, 1'b0);
    endtask

    task automatic good_boot(input string tag);
        start_seq(tag);
        bus_xfer({tag, ".wr"}, 1'b1, $urandom_range(0, 5), $urandom_range(1, 4), $urandom);
        bus_xfer({tag, ".rd"}, 1'b0, $urandom_range(0, 5), $urandom_range(1, 4), BOOT_VAL);
        fetch_phase(tag);
    endtask

    // Stay in RUN for idle cycles (optionally poking start), then raise done.
    task automatic run_to_done(input string tag, input int idle, input logic poke);
        int wrong;
        wrong = 0;
        for (int k = 0; k < idle; k++) begin
            gpio_out_i = $urandom & ~DONE_MASK;
            start_i    = poke && ($urandom_range(0, 1) == 1);
            tick();
            start_i = 1'b0;
            if (fetch_enable_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0 ||
                core_rst_n_o !== 1'b1 || error_o !== 1'b0)
                wrong++;
        end
        chk({tag, ".run_steady"}, wrong, 32'd0);
        gpio_out_i = $urandom | DONE_MASK;
        tick();
        gpio_out_i = 32'h0;
        chk1({tag, ".done"}, done_o, 1'b1);
        chk1({tag, ".done_busy"}, busy_o, 1'b0);
        chk1({tag, ".done_fetch"}, fetch_enable_o, 1'b1);
        chk1({tag, ".done_core_rst_n"}, core_rst_n_o, 1'b1);
        chk1({tag, ".done_error"}, error_o, 1'b0);
        chk1({tag, ".done_timeout"}, timeout_o, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int wrong;
        rst               = 1'b1;
        start_i           = 1'b0;
        gpio_out_i        = 32'h0;
        bus.data_gnt_i    = 1'b0;
        bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i  = 32'h0;
        repeat (3) tick();
        chk_reset_values("reset");
        rst = 1'b0;

        // Core reset stays asserted while idle after reset.
        wrong = 0;
        repeat ($urandom_range(2, 6)) begin
            tick();
            if (core_rst_n_o !== 1'b0 || busy_o !== 1'b0) wrong++;
        end
        chk("idle_after_reset", wrong, 32'd0);

        // Nominal boot: immediate grant, rvalid one cycle later.
        start_seq("b1");
        bus_xfer("b1.wr", 1'b1, 0, 1, $urandom);
        bus_xfer("b1.rd", 1'b0, 0, 1, BOOT_VAL);
        fetch_phase("b1");
        run_to_done("b1", $urandom_range(5, 30), 1'b1);

        // Restart from DONE, readback mismatch -> ERROR.
        start_seq("b2");
        bus_xfer("b2.wr", 1'b1, $urandom_range(0, 5), $urandom_range(1, 4), $urandom);
        bus_xfer("b2.rd", 1'b0, $urandom_range(0, 5), $urandom_range(1, 4), 32'hDEAD_BEEF);
        chk1("b2.error", error_o, 1'b1);
        chk1("b2.err_fetch", fetch_enable_o, 1'b0);
        chk1("b2.err_core_rst_n", core_rst_n_o, 1'b0);
        chk1("b2.err_busy", busy_o, 1'b0);
        chk1("b2.err_timeout", timeout_o, 1'b0);
        repeat (3) tick();
        chk1("b2.error_held", error_o, 1'b1);

        // Restart from ERROR, done bit never arrives -> timeout.
        good_boot("b3");
        n = 0;
        wrong = 0;
        while (error_o !== 1'b1 && n < LIMIT) begin
            if (fetch_enable_o !== 1'b1 || timeout_o !== 1'b0) wrong++;
            gpio_out_i = $urandom & ~DONE_MASK;
            n++;
            tick();
        end
        gpio_out_i = 32'h0;
        chk("b3.timeout_len", n, TMO);
        chk("b3.run_before_timeout", wrong, 32'd0);
        chk1("b3.timeout", timeout_o, 1'b1);
        chk1("b3.to_fetch", fetch_enable_o, 1'b0);
        chk1("b3.to_core_rst_n", core_rst_n_o, 1'b0);

        // Done bit in the last cycle before timeout wins.
        good_boot("b4");
        wrong = 0;
        for (int k = 0; k < int'(TMO) - 1; k++) begin
            gpio_out_i = $urandom & ~DONE_MASK;
            tick();
            if (error_o !== 1'b0 || done_o !== 1'b0) wrong++;
        end
        chk("b4.run_steady", wrong, 32'd0);
        gpio_out_i = DONE_MASK;
        tick();
        gpio_out_i = 32'h0;
        chk1("b4.done", done_o, 1'b1);
        chk1("b4.error", error_o, 1'b0);
        chk1("b4.timeout", timeout_o, 1'b0);

        // Grant withheld 37 cycles, then reset mid-transaction.
        start_seq("b5");
        hold_no_grant("b5.wr", 1'b1, 37);
        rst = 1'b1;
        tick();
        chk_reset_values("midreset");
        rst = 1'b0;
        tick();
        chk({"midreset.state_after"}, {28'h0, state_o}, {28'h0, IDLE});

        // Full recovery from IDLE with random timing.
        good_boot("b6");
        run_to_done("b6", $urandom_range(0, 10), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
